// File: rtl/alu_muldiv_iterative.sv
// Iterative multiply/divide unit for the HI/LO operations (MULT, MULTU, DIV, DIVU).
// One result bit per cycle: radix-2 shift-add multiply, radix-2 restoring divide.
// Signed operands are reduced to magnitudes on capture; signs are re-applied on
// the final iteration edge.
//
// Ports:
//   clk_i, resetn_i     clock, asynchronous active-low reset
//   start_i, op_i       request + opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   src_a_i, src_b_i    multiplicand/dividend, multiplier/divisor (read on start only)
//   flush_i             cancel in-flight work; beats start and completion
//   busy_o, done_o      computing / one-cycle result-valid pulse
//   result_hi_o/_lo_o   product {hi,lo}, or {remainder, quotient}
//   div_by_zero_o       sticky until the next accepted start
module alu_muldiv_iterative #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic [WIDTH-1:0] result_lo_o,
  output logic             div_by_zero_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;   // dividend as captured, for divide-by-zero
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand magnitude, or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;       // {upper, multiplier} or {remainder, quotient}
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               dbz_q, dbz_d;

  // Capture-side operand conditioning
  logic             sa_in, sb_in, accept, last;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign sa_in  = ~op_i[0] & src_a_i[WIDTH-1];
  assign sb_in  = ~op_i[0] & src_b_i[WIDTH-1];
  assign a_mag  = sa_in ? -src_a_i : src_a_i;
  assign b_mag  = sb_in ? -src_b_i : src_b_i;
  assign accept = start_i & ~flush_i & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign last   = (cnt_q == CNT_W'(WIDTH - 1));

  // One iteration of the selected algorithm
  logic [WIDTH:0]     mul_sum, div_top, div_trial;
  logic [2*WIDTH-1:0] step;
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    // remainder shifted left with the next dividend bit; needs WIDTH+1 bits
    // because the remainder can be as large as divisor-1 ~ 2^WIDTH
    div_top   = acc_q[2*WIDTH-1:WIDTH-1];
    div_trial = div_top - {1'b0, opnd_q};
    if (!op_q[1])
      step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    else if (div_trial[WIDTH])
      step = {div_top[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    else
      step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  // Sign fix-up of the finished iteration
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  always_comb begin
    prod = step;
    if ((op_q == 2'b00) && (sign_a_q ^ sign_b_q)) prod = -step;
    quo = step[WIDTH-1:0];
    rem = step[2*WIDTH-1:WIDTH];
    if (~op_q[0] & (sign_a_q ^ sign_b_q)) quo = -quo;
    if (sign_a_q) rem = -rem;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_raw_d  = a_raw_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_BUSY: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + CNT_W'(1);
          if (last) begin
            state_d = S_DONE;
            if (!op_q[1]) begin
              {hi_d, lo_d} = prod;
            end else if (opnd_q == '0) begin
              hi_d  = a_raw_q;
              lo_d  = '1;
              dbz_d = 1'b1;
            end else begin
              hi_d = rem;
              lo_d = quo;
            end
          end
        end
      end
      default: begin  // IDLE, DONE (and the unused encoding)
        state_d = S_IDLE;
        if (accept) begin
          state_d  = S_BUSY;
          op_d     = op_i;
          sign_a_d = sa_in;
          sign_b_d = sb_in;
          a_raw_d  = src_a_i;
          opnd_d   = op_i[1] ? b_mag : a_mag;
          acc_d    = {{WIDTH{1'b0}}, (op_i[1] ? a_mag : b_mag)};
          cnt_d    = '0;
          dbz_d    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_raw_q  <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_raw_q  <= a_raw_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy_o        = (state_q == S_BUSY);
  assign done_o        = (state_q == S_DONE);
  assign result_hi_o   = hi_q;
  assign result_lo_o   = lo_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_iterative.sv
// Bench for alu_muldiv_iterative: a WIDTH=32 and a WIDTH=8 instance, directed
// operations, an arithmetic reference model and a per-cycle output comparator.
module tb_alu_muldiv_iterative;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        start[2], flush[2];
  logic [1:0]  op[2];
  logic [31:0] a[2], b[2];
  logic        busy[2], done[2], dz[2];
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  alu_muldiv_iterative #(.WIDTH(32)) u_dut32 (
    .clk_i(clk), .resetn_i(rstn), .start_i(start[0]), .op_i(op[0]),
    .src_a_i(a[0]), .src_b_i(b[0]), .flush_i(flush[0]), .busy_o(busy[0]),
    .done_o(done[0]), .result_hi_o(hi32), .result_lo_o(lo32), .div_by_zero_o(dz[0]));

  alu_muldiv_iterative #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .resetn_i(rstn), .start_i(start[1]), .op_i(op[1]),
    .src_a_i(a[1][7:0]), .src_b_i(b[1][7:0]), .flush_i(flush[1]), .busy_o(busy[1]),
    .done_o(done[1]), .result_hi_o(hi8), .result_lo_o(lo8), .div_by_zero_o(dz[1]));

  int nchk = 0, nerr = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          dut;
    logic [31:0] ehi, elo;
    logic        edz;
    int          acc, dcyc;
  } item_t;
  item_t q[$];

  logic [31:0] h_hi[2], h_lo[2];
  logic        h_dz[2];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands
  function automatic void model(int w, logic [1:0] o, logic [31:0] x, logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el,
                                output logic ez);
    logic [63:0] m, ux, uy;
    longint sx, sy, p, qq, rr;
    m  = (64'd1 << w) - 64'd1;
    ux = {32'h0, x} & m;
    uy = {32'h0, y} & m;
    sx = (!o[0] && ux[w-1]) ? longint'(ux) - (longint'(1) << w) : longint'(ux);
    sy = (!o[0] && uy[w-1]) ? longint'(uy) - (longint'(1) << w) : longint'(uy);
    ez = 1'b0;
    if (!o[1]) begin
      p  = sx * sy;
      eh = 32'((p >> w) & m);
      el = 32'(p & m);
    end else if (uy == 0) begin
      eh = 32'(ux);
      el = 32'(m);
      ez = 1'b1;
    end else begin
      qq = sx / sy;
      rr = sx % sy;
      eh = 32'(rr & m);
      el = 32'(qq & m);
    end
  endfunction

  // Per-cycle comparator against the expectation queue and held results
  always @(negedge clk) begin
    int k;
    bit eb, ed;
    logic [31:0] ahi, alo;
    for (int d = 0; d < 2; d++) begin
      k = -1;
      for (int i = 0; i < q.size(); i++) if (q[i].dut == d && k < 0) k = i;
      if (!rstn) begin
        h_hi[d] = '0; h_lo[d] = '0; h_dz[d] = 1'b0;
      end
      eb = (k >= 0) && (cyc >= q[k].acc) && (cyc < q[k].dcyc);
      ed = (k >= 0) && (cyc == q[k].dcyc);
      if (ed) begin
        h_hi[d] = q[k].ehi; h_lo[d] = q[k].elo; h_dz[d] = q[k].edz;
        q.delete(k);
      end
      ahi = d ? {24'h0, hi8} : hi32;
      alo = d ? {24'h0, lo8} : lo32;
      chk($sformatf("busy[%0d]", d), 64'(busy[d]), 64'(eb));
      chk($sformatf("done[%0d]", d), 64'(done[d]), 64'(ed));
      chk($sformatf("hi[%0d]", d), 64'(ahi), 64'(h_hi[d]));
      chk($sformatf("lo[%0d]", d), 64'(alo), 64'(h_lo[d]));
      if (ed || !rstn) chk($sformatf("dbz[%0d]", d), 64'(dz[d]), 64'(h_dz[d]));
    end
  end

  // Drive a start for one cycle (caller sits just after a rising edge)
  task automatic go(int d, logic [1:0] o, logic [31:0] x, logic [31:0] y);
    item_t it;
    int w;
    w = d ? 8 : 32;
    model(w, o, x, y, it.ehi, it.elo, it.edz);
    it.dut = d; it.acc = cyc + 1; it.dcyc = cyc + 1 + w;
    op[d] = o; a[d] = x; b[d] = y; start[d] = 1'b1;
    q.push_back(it);
    @(posedge clk); #1;
    start[d] = 1'b0;
  endtask

  task automatic run(int d, logic [1:0] o, logic [31:0] x, logic [31:0] y);
    go(d, o, x, y);
    repeat ((d ? 8 : 32) + 1) @(posedge clk);
    #1;
  endtask

  task automatic drop(int d);
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].dut == d) q.delete(i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] eh, el;
    logic ez;
    rstn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 0; flush[d] = 0; op[d] = 0; a[d] = 0; b[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy[0]), 64'd0);
    chk("reset_hi", 64'(hi32), 64'd0);
    chk("reset_lo", 64'(lo32), 64'd0);
    rstn = 1'b1;

    // pin the model with hand-computed values
    model(32, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, eh, el, ez);
    chk("model_multu", {eh, el}, 64'hFFFFFFFE_00000001);
    model(32, 2'b00, 32'hFFFFFFFD, 32'd7, eh, el, ez);
    chk("model_mult_neg", {eh, el}, 64'hFFFFFFFF_FFFFFFEB);
    model(32, 2'b10, 32'hFFFFFFF9, 32'd2, eh, el, ez);
    chk("model_div_neg", {eh, el}, 64'hFFFFFFFF_FFFFFFFD);
    model(32, 2'b10, 32'h80000000, 32'hFFFFFFFF, eh, el, ez);
    chk("model_div_ovf", {eh, el}, 64'h00000000_80000000);
    model(8, 2'b00, 32'h80, 32'h80, eh, el, ez);
    chk("model_mult8", {eh, el}, 64'h00000040_00000000);

    // WIDTH=32 arithmetic
    run(0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_hi", 64'(hi32), 64'hFFFFFFFE);
    chk("multu_lo", 64'(lo32), 64'h00000001);
    run(0, 2'b00, 32'h80000000, 32'h80000000);
    chk("mult_min_hi", 64'(hi32), 64'h40000000);
    run(0, 2'b00, 32'hFFFFFFFD, 32'd7);
    run(0, 2'b10, 32'hFFFFFFF9, 32'd2);
    chk("div_neg_lo", 64'(lo32), 64'hFFFFFFFD);
    run(0, 2'b11, 32'd100, 32'd7);
    chk("divu_lo", 64'(lo32), 64'd14);
    chk("divu_hi", 64'(hi32), 64'd2);
    run(0, 2'b10, 32'h80000000, 32'hFFFFFFFF);
    run(0, 2'b10, 32'h00000007, 32'hFFFFFFFE);
    run(0, 2'b11, 32'd5, 32'd0);
    chk("dbz_set", 64'(dz[0]), 64'd1);
    chk("dbz_hi", 64'(hi32), 64'd5);
    go(0, 2'b01, 32'd3, 32'd4);
    chk("dbz_cleared", 64'(dz[0]), 64'd0);
    repeat (33) @(posedge clk);
    #1;

    // flush at busy cycle 10: no done, results keep 12
    go(0, 2'b01, 32'd6, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    flush[0] = 1'b1;
    @(posedge clk); #1;
    flush[0] = 1'b0;
    drop(0);
    chk("flush_idle", 64'(busy[0]), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("flush_hold", 64'(lo32), 64'd12);

    // back-to-back: start in the DONE cycle
    go(0, 2'b11, 32'd100, 32'd7);
    repeat (32) @(posedge clk);
    #1;
    chk("b2b_done", 64'(done[0]), 64'd1);
    run(0, 2'b00, 32'hFFFFFFFD, 32'd7);

    // flush in DONE: pulse still seen, start suppressed
    go(0, 2'b01, 32'd2, 32'd3);
    repeat (32) @(posedge clk);
    #1;
    flush[0] = 1'b1; start[0] = 1'b1; op[0] = 2'b01; a[0] = 32'd9; b[0] = 32'd9;
    @(posedge clk); #1;
    flush[0] = 1'b0; start[0] = 1'b0;
    chk("flush_done_nostart", 64'(busy[0]), 64'd0);
    repeat (2) @(posedge clk);
    #1;

    // asynchronous reset at busy cycle 5
    go(0, 2'b01, 32'd11, 32'd13);
    repeat (4) @(posedge clk);
    #2;
    rstn = 1'b0;
    q.delete();
    #1;
    chk("rst_busy", 64'(busy[0]), 64'd0);
    chk("rst_done", 64'(done[0]), 64'd0);
    chk("rst_res", {hi32, lo32}, 64'd0);
    chk("rst_dbz", 64'(dz[0]), 64'd0);
    @(posedge clk); #2;
    rstn = 1'b1;
    @(posedge clk); #1;
    run(0, 2'b11, 32'd100, 32'd7);

    // WIDTH=8 instance
    run(1, 2'b00, 32'h80, 32'h80);
    chk("mult8_hi", 64'(hi8), 64'h40);
    chk("mult8_lo", 64'(lo8), 64'h00);
    run(1, 2'b10, 32'h80, 32'hFF);
    chk("div8_ovf_lo", 64'(lo8), 64'h80);
    run(1, 2'b11, 32'hFF, 32'h10);
    run(1, 2'b10, 32'hF9, 32'h00);
    chk("div8_dbz", 64'(dz[1]), 64'd1);
    run(1, 2'b01, 32'hFF, 32'hFF);
    run(1, 2'b10, 32'hF9, 32'h02);

    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_iterative.md
Name: alu_muldiv_iterative

Overview:
- Parametrised, multi-cycle multiply/divide unit for the execute stage.
- Generalises the single-cycle ALU datapath to the HI/LO operations: MULT, MULTU, DIV and DIVU.
- Computes iteratively, one bit per cycle, and returns a {hi, lo} pair for the HI/LO register write.
- Uses a start/busy/done handshake and a flush input so that an exception in an older instruction can cancel work in flight.

Parameters:
- WIDTH, 32: operand width in bits. Must be even and ≥ 8. Results are 2×WIDTH wide.
- CNT_W, $clog2(WIDTH)+1: width of the iteration counter. Derived; do not override.

Ports:
- clk, input, 1: single clock. All state updates on rising edge.
- resetn, input, 1: asynchronous, active-low reset.
- start, input, 1: request a new operation. Sampled only in IDLE or DONE.
- op, input, 2: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU. Captured with start.
- src_a, input, WIDTH: multiplicand / dividend (rs).
- src_b, input, WIDTH: multiplier / divisor (rt).
- flush, input, 1: synchronous cancel. Has priority over start and completion.
- busy, output, 1: high while computing. Upstream stalls while it is high.
- done, output, 1: one-cycle pulse; result_hi/result_lo are valid in this cycle.
- result_hi, output, WIDTH: MULT* gives the upper product half; DIV* gives the remainder.
- result_lo, output, WIDTH: MULT* gives the lower product half; DIV* gives the quotient.
- div_by_zero, output, 1: registered flag. Set with done when a DIV* had src_b==0; cleared on the next accepted start.

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, busy=0, done=0, result_hi=0, result_lo=0, div_by_zero=0, counter=0, internal operand registers=0.
- States:
  - IDLE to BUSY on start && !flush.
  - BUSY to DONE when counter reaches WIDTH-1 on the current edge, with no flush.
  - BUSY to IDLE on flush.
  - DONE to BUSY on start && !flush (back-to-back operation).
  - DONE to IDLE otherwise.
- Capture on the accepting edge:
  - Latch op and the operand sign bits.
  - For signed ops, convert operands to magnitude (two's-complement negate if negative).
  - Clear the counter and the accumulator/partial-remainder.
- Multiply (shift-add, radix-2): each BUSY cycle, if the multiplier LSB=1, add the multiplicand into the upper half of the 2×WIDTH accumulator (WIDTH+1-bit add, carry kept), then shift right by one.
- Divide (restoring, radix-2): each BUSY cycle:
  - Shift {remainder, quotient} left by one.
  - Trial-subtract the divisor magnitude from the remainder (WIDTH+1 bits).
  - If non-negative, keep the result and set quotient bit 0; otherwise restore.
- Latency: start accepted at edge N. busy=1 during cycles N+1..N+WIDTH. done=1 and results valid during cycle N+WIDTH+1 (33 cycles for WIDTH=32).
- Sign fix-up is applied on the BUSY to DONE edge:
  - MULT: negate the 2×WIDTH product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; give the remainder the dividend's sign. Quotient truncates toward zero.
- Divide by zero:
  - No trap; full latency still applies.
  - result_lo = all ones. result_hi = src_a as captured (original value, not magnitude).
  - div_by_zero=1.
- Signed DIV of most-negative by -1: quotient = 0x8000…0, remainder = 0. No flag, no exception.
- result_hi/result_lo update only on the BUSY to DONE edge. They hold their value through IDLE, BUSY and flush until the next completion.
- start in BUSY is ignored; the unit does not queue requests. start in DONE is accepted; done and busy never assert in the same cycle.
- flush:
  - In BUSY: go to IDLE on the next edge. No done pulse; results and div_by_zero unchanged.
  - In DONE: done still pulses that cycle (already committed), and start is suppressed.
  - In IDLE: no effect.
- Reset asserted mid-operation: immediately return to the reset values above; no done.
- Operands must be held by upstream only on the start cycle. The unit never re-reads src_a/src_b after capture.

Test Plan:
- MULTU 0xFFFFFFFF×0xFFFFFFFF, WIDTH=32 -> done at cycle 33 after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 32 cycles.
- MULT 0x80000000×0x80000000 -> hi=0x40000000, lo=0. MULT 0xFFFFFFFD(-3)×7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 -> done after 33 cycles; lo=0xFFFFFFFF, hi=5, div_by_zero=1. Next start clears div_by_zero.
- Start MULTU, assert flush at busy cycle 10 -> IDLE next edge, no done, results retain previous values. Then a start in the DONE cycle of another operation -> back-to-back; done for the second op appears exactly 33 cycles later.
- Deassert resetn at busy cycle 5 -> all outputs 0 asynchronously. Repeat the test with WIDTH=8 (MULT -128×-128 -> hi=0x40, lo=0x00; latency 9).
